kx4_bbint_ctl: RTL and testbench

Interrupt capture and arbitration stage that sits directly downstream of the capture mux. It consumes the OR-merged BBINT0..BBINT13 lines, which are asynchronous to CLK.
- Synchronizes each line and captures it into per-channel pending flags (edge or level mode).
- Applies a mask, then picks one channel with a fixed-priority encoder.
- Presents the winner to the CPU interrupt controller over a req/ack handshake.

---
 rtl/kx4_bbint_pkg.sv | 23 ++
 rtl/kx4_bbint_sync.sv | 29 ++
 rtl/kx4_bbint_ctl.sv | 140 ++++++++++++++
 tb/tb_kx4_bbint_ctl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/kx4_bbint_pkg.sv
// Shared encodings, widths and reset constants for the BBINT interrupt controller.
package kx4_bbint_pkg;

   localparam int unsigned VW = 4;
   localparam int unsigned RW = 16;

   typedef enum logic [1:0] {
      SEL_MK    = 2'd0,
      SEL_MD    = 2'd1,
      SEL_IFCLR = 2'd2,
      SEL_RSVD  = 2'd3
   } regsel_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam logic [RW-1:0] MK_RST = '1;
   localparam logic [RW-1:0] MD_RST = '0;

endpackage

// File: rtl/kx4_bbint_sync.sv
// Multi-flop synchronizer for one asynchronous BBINT line, plus a history flop
// so the caller gets both the synchronized level and a single-cycle rise pulse.
module kx4_bbint_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level  = sync_q[SYNC_STAGES-1];
   assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/kx4_bbint_ctl.sv
// BBINT capture, mask, fixed-priority arbitration and req/ack handshake to the CPU.
// Build option KX4_BBINT_TTRG_EN adds TTRG2 as an extra lowest-priority edge channel.
module kx4_bbint_ctl
   import kx4_bbint_pkg::*;
#(
   parameter int unsigned NCH         = 14,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic           CLK,
   input  logic           RESB,
   input  logic [NCH-1:0] BBINT,
   input  logic           TTRG2,
   input  logic           REGWR,
   input  logic [1:0]     REGSEL,
   input  logic [RW-1:0]  REGWD,
   output logic [RW-1:0]  IFRD,
   output logic [RW-1:0]  MKRD,
   output logic           INTREQ,
   output logic [VW-1:0]  INTVEC,
   input  logic           INTACK
);

`ifdef KX4_BBINT_TTRG_EN
   localparam int unsigned NF = NCH + 1;
`else
   localparam int unsigned NF = NCH;
`endif

   logic [NF-1:0]  if_q, mk_q;
   logic [NCH-1:0] md_q;
   logic [NCH-1:0] lvl, rise_c;
   logic [NF-1:0]  set_c, clr_c, cand_c;
   logic [VW-1:0]  win_c;
   logic           ack_c;
   logic           wr_mk_c, wr_md_c, wr_clr_c;
   state_e         state_q, state_d;
   logic           intreq_d;
   logic [VW-1:0]  intvec_d;

   for (genvar g = 0; g < NCH; g++) begin : g_sync
      kx4_bbint_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk    (CLK),
         .rst_n  (RESB),
         .d      (BBINT[g]),
         .level  (lvl[g]),
         .rise_c (rise_c[g])
      );
   end

`ifdef KX4_BBINT_TTRG_EN
   // TTRG2 is already in the CLK domain; only an edge detector is needed
   logic ttrg_hist_q;
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) ttrg_hist_q <= 1'b0;
      else       ttrg_hist_q <= TTRG2;
   end
`endif

   always_comb begin
      set_c            = '0;
      set_c[NCH-1:0]   = (md_q & lvl) | (~md_q & rise_c);
`ifdef KX4_BBINT_TTRG_EN
      set_c[NCH]       = TTRG2 & ~ttrg_hist_q;
`endif
   end

   assign wr_mk_c  = REGWR && (regsel_e'(REGSEL) == SEL_MK);
   assign wr_md_c  = REGWR && (regsel_e'(REGSEL) == SEL_MD);
   assign wr_clr_c = REGWR && (regsel_e'(REGSEL) == SEL_IFCLR);

   assign clr_c  = (wr_clr_c ? REGWD[NF-1:0] : '0) |
                   (ack_c ? (NF'(1) << INTVEC) : '0);
   assign cand_c = if_q & ~mk_q;

   // Lowest pending unmasked index wins
   always_comb begin
      win_c = '0;
      for (int i = NF - 1; i >= 0; i--) begin
         if (cand_c[i]) win_c = VW'(i);
      end
   end

   // Set is applied after clear so a coincident set wins
   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         if_q <= '0;
         mk_q <= MK_RST[NF-1:0];
         md_q <= MD_RST[NCH-1:0];
      end else begin
         if_q <= (if_q & ~clr_c) | set_c;
         if (wr_mk_c) mk_q <= REGWD[NF-1:0];
         if (wr_md_c) md_q <= REGWD[NCH-1:0];
      end
   end

   always_ff @(posedge CLK or negedge RESB) begin
      if (!RESB) begin
         state_q <= IDLE;
         INTREQ  <= 1'b0;
         INTVEC  <= '0;
      end else begin
         state_q <= state_d;
         INTREQ  <= intreq_d;
         INTVEC  <= intvec_d;
      end
   end

   // Request is held unconditionally in REQ until acknowledged
   always_comb begin
      state_d  = state_q;
      intreq_d = INTREQ;
      intvec_d = INTVEC;
      ack_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|cand_c) begin
               intreq_d = 1'b1;
               intvec_d = win_c;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (INTACK) begin
               ack_c    = 1'b1;
               intreq_d = 1'b0;
               state_d  = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign IFRD = RW'(if_q);
   assign MKRD = RW'(mk_q);

   logic unused_ok;
   assign unused_ok = ^{REGWD, TTRG2};

endmodule

// File: tb/tb_kx4_bbint_ctl.sv
// Directed self-checking bench for kx4_bbint_ctl (default NCH=14, SYNC_STAGES=2).
module tb_kx4_bbint_ctl;
   import kx4_bbint_pkg::*;

`ifdef KX4_BBINT_TTRG_EN
   localparam logic [15:0] MK_ALL = 16'h7FFF;
`else
   localparam logic [15:0] MK_ALL = 16'h3FFF;
`endif

   logic        CLK = 1'b0;
   logic        RESB;
   logic [13:0] BBINT;
   logic        TTRG2;
   logic        REGWR;
   logic [1:0]  REGSEL;
   logic [15:0] REGWD;
   logic [15:0] IFRD, MKRD;
   logic        INTREQ;
   logic [3:0]  INTVEC;
   logic        INTACK;

   int checks   = 0;
   int failures = 0;

   kx4_bbint_ctl dut (
      .CLK    (CLK),
      .RESB   (RESB),
      .BBINT  (BBINT),
      .TTRG2  (TTRG2),
      .REGWR  (REGWR),
      .REGSEL (REGSEL),
      .REGWD  (REGWD),
      .IFRD   (IFRD),
      .MKRD   (MKRD),
      .INTREQ (INTREQ),
      .INTVEC (INTVEC),
      .INTACK (INTACK)
   );

   always #5 CLK = ~CLK;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] sel, input logic [15:0] data);
      REGWR = 1'b1; REGSEL = sel; REGWD = data;
      tick();
      REGWR = 1'b0; REGWD = '0;
   endtask

   task automatic ack();
      INTACK = 1'b1;
      tick();
      INTACK = 1'b0;
   endtask

   initial begin
      RESB = 1'b0; BBINT = '0; TTRG2 = 1'b0; REGWR = 1'b0;
      REGSEL = '0; REGWD = '0; INTACK = 1'b0;
      tick(2);
      chk("rst_if",  IFRD, 16'h0000);
      chk("rst_mk",  MKRD, MK_ALL);
      chk("rst_req", 16'(INTREQ), 16'h0);
      chk("rst_vec", 16'(INTVEC), 16'h0);
      RESB = 1'b1;
      tick();

      // edge basics
      wr(SEL_MK, 16'h0000);
      chk("mk_clear", MKRD, 16'h0000);
      BBINT[5] = 1'b1;
      tick(2);
      chk("e5_if_k1", IFRD, 16'h0000);
      tick();
      chk("e5_if_k2", IFRD, 16'h0020);
      chk("e5_req_k2", 16'(INTREQ), 16'h0);
      tick();
      chk("e5_req_k3", 16'(INTREQ), 16'h1);
      chk("e5_vec", 16'(INTVEC), 16'd5);
      BBINT[5] = 1'b0;
      ack();
      chk("e5_ack_if", IFRD, 16'h0000);
      chk("e5_ack_req", 16'(INTREQ), 16'h0);
      tick(2);
      chk("e5_idle_req", 16'(INTREQ), 16'h0);

      // priority
      BBINT[9] = 1'b1; BBINT[2] = 1'b1;
      tick(3);
      chk("pri_if", IFRD, 16'h0204);
      tick();
      chk("pri_req1", 16'(INTREQ), 16'h1);
      chk("pri_vec1", 16'(INTVEC), 16'd2);
      ack();
      chk("pri_ack1_if", IFRD, 16'h0200);
      chk("pri_ack1_req", 16'(INTREQ), 16'h0);
      tick();
      chk("pri_gap_req", 16'(INTREQ), 16'h0);
      tick();
      chk("pri_req2", 16'(INTREQ), 16'h1);
      chk("pri_vec2", 16'(INTVEC), 16'd9);
      ack();
      chk("pri_ack2_if", IFRD, 16'h0000);
      tick(3);
      chk("pri_done_req", 16'(INTREQ), 16'h0);
      BBINT = '0;

      // mask and hold
      wr(SEL_MK, 16'h0010);
      BBINT[4] = 1'b1;
      tick(4);
      chk("mk_if4", IFRD, 16'h0010);
      chk("mk_noreq", 16'(INTREQ), 16'h0);
      BBINT[4] = 1'b0;
      wr(SEL_MK, 16'h0000);
      tick();
      chk("mk_req", 16'(INTREQ), 16'h1);
      chk("mk_vec", 16'(INTVEC), 16'd4);
      wr(SEL_MK, 16'h0010);
      wr(SEL_IFCLR, 16'h0010);
      chk("hold_if", IFRD, 16'h0000);
      chk("hold_req", 16'(INTREQ), 16'h1);
      chk("hold_vec", 16'(INTVEC), 16'd4);
      ack();
      chk("hold_ack_req", 16'(INTREQ), 16'h0);
      tick(2);
      chk("hold_after_req", 16'(INTREQ), 16'h0);
      wr(SEL_MK, 16'h0000);

      // level mode
      wr(SEL_MD, 16'h0008);
      BBINT[3] = 1'b1;
      tick(4);
      chk("lvl_req1", 16'(INTREQ), 16'h1);
      chk("lvl_vec1", 16'(INTVEC), 16'd3);
      ack();
      tick();
      chk("lvl_reset_if", IFRD, 16'h0008);
      tick();
      chk("lvl_req2", 16'(INTREQ), 16'h1);
      chk("lvl_vec2", 16'(INTVEC), 16'd3);
      BBINT[3] = 1'b0;
      tick(4);
      ack();
      chk("lvl_drop_if", IFRD, 16'h0000);
      tick(3);
      chk("lvl_drop_req", 16'(INTREQ), 16'h0);
      chk("lvl_drop_if2", IFRD, 16'h0000);
      wr(SEL_MD, 16'h0000);

      // set/clear collision on channel 6
      BBINT[6] = 1'b1;
      tick(2);
      REGWR = 1'b1; REGSEL = SEL_IFCLR; REGWD = 16'h0040;
      tick();
      REGWR = 1'b0; REGWD = '0;
      chk("coll_if", IFRD, 16'h0040);
      tick();
      chk("coll_req", 16'(INTREQ), 16'h1);
      chk("coll_vec", 16'(INTVEC), 16'd6);

      // asynchronous reset mid-request
      #2 RESB = 1'b0;
      #1;
      chk("arst_req", 16'(INTREQ), 16'h0);
      chk("arst_mk", MKRD, MK_ALL);
      chk("arst_if", IFRD, 16'h0000);
      BBINT = '0;
      #1 RESB = 1'b1;
      tick();
      wr(SEL_MK, 16'h0000);

`ifdef KX4_BBINT_TTRG_EN
      BBINT[13] = 1'b1;
      tick(2);
      TTRG2 = 1'b1;
      tick();
      TTRG2 = 1'b0;
      chk("tt_if", IFRD, 16'h6000);
      tick();
      chk("tt_vec1", 16'(INTVEC), 16'd13);
      chk("tt_req1", 16'(INTREQ), 16'h1);
      ack();
      chk("tt_ack1_if", IFRD, 16'h4000);
      tick(2);
      chk("tt_vec2", 16'(INTVEC), 16'd14);
      chk("tt_req2", 16'(INTREQ), 16'h1);
      ack();
      chk("tt_ack2_if", IFRD, 16'h0000);
      BBINT = '0;
`else
      TTRG2 = 1'b1;
      tick();
      TTRG2 = 1'b0;
      tick(4);
      chk("tt_off_req", 16'(INTREQ), 16'h0);
      chk("tt_off_if", IFRD, 16'h0000);
      wr(SEL_MK, 16'hFFFF);
      chk("tt_off_mk", MKRD, 16'h3FFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
